// File: rtl/npc_ctrl_pkg.sv
// Shared definitions for the NPC control FSM: state encodings and error codes.
// The optional performance counters in npc_ctrl are enabled by defining NPC_PERF_CNT_EN.
package npc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERR    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_IMEM_TO = 2'd2,
    ERR_DMEM_TO = 2'd3
  } err_t;

endpackage

// File: rtl/npc_ctrl_wdt.sv
// Handshake watchdog: counts consecutive wait cycles and flags the cycle on which
// the TIMEOUT_LIMIT-th wait cycle occurs.
module npc_ctrl_wdt #(
  parameter int unsigned TIMEOUT_W     = 8,
  parameter int unsigned TIMEOUT_LIMIT = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_LIMIT - 1);

  logic [TIMEOUT_W-1:0] r_cnt;

  // r_cnt holds the number of wait cycles already elapsed, so the current cycle is r_cnt+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_wait && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_wait && (r_cnt == LAST);

endmodule

// File: rtl/npc_ctrl.sv
// Multi-cycle control FSM for the NPC core: fetch/decode/exec/mem/writeback sequencing,
// memory handshakes, halt/illegal/timeout detection. Optional counters: NPC_PERF_CNT_EN.
module npc_ctrl
  import npc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W     = 8,
  parameter int unsigned TIMEOUT_LIMIT = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_valid,
  input  logic        imem_ready,
  output logic        dmem_valid,
  output logic        dmem_wr,
  input  logic        dmem_ready,
  input  logic        dec_is_load,
  input  logic        dec_mem_wen,
  input  logic        dec_reg_wen,
  input  logic        dec_is_ebreak,
  input  logic        dec_inst_not_ipl,
  output logic        ir_wen,
  output logic        pc_wen,
  output logic        rf_wen,
  output logic        halt,
  output logic [1:0]  err_code,
  output logic [2:0]  state
`ifdef NPC_PERF_CNT_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  state_t r_state;
  err_t   r_err_code;
  logic   r_dmem_wr;
  logic   w_wdt_clear;
  logic   w_wdt_wait;
  logic   w_expired;

  assign w_wdt_clear = (r_state != FETCH) && (r_state != MEM);
  assign w_wdt_wait  = ((r_state == FETCH) && !imem_ready) ||
                       ((r_state == MEM)   && !dmem_ready);

  npc_ctrl_wdt #(
    .TIMEOUT_W     (TIMEOUT_W),
    .TIMEOUT_LIMIT (TIMEOUT_LIMIT)
  ) u_wdt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_wdt_clear),
    .i_wait    (w_wdt_wait),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_err_code <= ERR_NONE;
      r_dmem_wr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE:   r_state <= FETCH;
        FETCH: begin
          // ready takes priority over a watchdog expiry in the same cycle
          if (imem_ready) begin
            r_state <= DECODE;
          end else if (w_expired) begin
            r_state    <= ERR;
            r_err_code <= ERR_IMEM_TO;
          end
        end
        DECODE: begin
          if (dec_is_ebreak) begin
            r_state <= HALT;
          end else if (dec_inst_not_ipl) begin
            r_state    <= ERR;
            r_err_code <= ERR_ILLEGAL;
          end else begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (dec_is_load || dec_mem_wen) begin
            r_state   <= MEM;
            r_dmem_wr <= dec_mem_wen;
          end else begin
            r_state <= WB;
          end
        end
        MEM: begin
          if (dmem_ready) begin
            r_state <= WB;
          end else if (w_expired) begin
            r_state    <= ERR;
            r_err_code <= ERR_DMEM_TO;
          end
        end
        WB:     r_state <= FETCH;
        HALT:   r_state <= HALT;
        ERR:    r_state <= ERR;
      endcase
    end
  end

  assign imem_valid = (r_state == FETCH);
  assign dmem_valid = (r_state == MEM);
  assign dmem_wr    = (r_state == MEM) && r_dmem_wr;
  assign ir_wen     = (r_state == FETCH) && imem_ready;
  assign pc_wen     = (r_state == WB);
  assign rf_wen     = (r_state == WB) && dec_reg_wen;
  assign halt       = (r_state == HALT) || (r_state == ERR);
  assign err_code   = r_err_code;
  assign state      = r_state;

`ifdef NPC_PERF_CNT_EN
  logic [63:0] r_cycle_cnt;
  logic [63:0] r_instret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (!halt) begin
        r_cycle_cnt <= r_cycle_cnt + 64'd1;
      end
      if (pc_wen) begin
        r_instret_cnt <= r_instret_cnt + 64'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule
